conv_seq_ctrl: RTL

Sequencing controller for the 1-D convolution datapath: x buffer, f buffer and one MAC accumulator.
- Accepts DATA_N samples and FILTER_N taps over valid/ready streams and drives their buffer writes.
- Steps the MAC through FILTER_N cycles per output and presents each of the CONV_N results on a valid/ready output.
- Sits beside the datapath under the conv top level, as a drop-in alternative sequencer with a run-complete pulse.

---
 rtl/conv_seq_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: load/compute/output sequencer for the 1-D conv datapath.
// Optional `CONV_FILTER_REUSE_EN: keep taps loaded after the first run.
module conv_seq_ctrl #(
  parameter int DATA_N      = 8,
  parameter int FILTER_N    = 4,
  parameter int CONV_N      = DATA_N - FILTER_N + 1,
  parameter int LG_DATA_N   = $clog2(DATA_N),
  parameter int LG_FILTER_N = $clog2(FILTER_N),
  parameter int LG_CONV_N   = $clog2(CONV_N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid_x,
  output logic                   s_ready_x,
  input  logic                   s_valid_f,
  output logic                   s_ready_f,
  input  logic                   m_ready_y,
  output logic                   m_valid_y,
  output logic [LG_DATA_N-1:0]   addr_x,
  output logic                   wr_en_x,
  output logic [LG_FILTER_N-1:0] addr_f,
  output logic                   wr_en_f,
  output logic                   clear_acc,
  output logic                   en_acc,
  output logic                   run_done
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMP,
    S_OUT
  } state_t;

  localparam logic [LG_DATA_N:0] X_FULL =
    (LG_DATA_N+1)'(DATA_N);
  localparam logic [LG_FILTER_N:0] F_FULL =
    (LG_FILTER_N+1)'(FILTER_N);
  localparam logic [LG_FILTER_N-1:0] K_LAST =
    LG_FILTER_N'(FILTER_N-1);
  localparam logic [LG_CONV_N-1:0] N_LAST =
    LG_CONV_N'(CONV_N-1);

  state_t                 r_state, w_state_nxt;
  logic [LG_DATA_N:0]     r_cnt_x, w_cnt_x_nxt;
  logic [LG_FILTER_N:0]   r_cnt_f, w_cnt_f_nxt;
  logic [LG_FILTER_N-1:0] r_k, w_k_nxt;
  logic [LG_CONV_N-1:0]   r_n, w_n_nxt;
  logic                   r_live;
  logic                   w_f_reuse;
  logic                   w_full_x;
  logic                   w_full_f;
  logic [LG_DATA_N-1:0]   w_nk;

`ifdef CONV_FILTER_REUSE_EN
  logic r_floaded;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_floaded <= 1'b0;
    end else if (w_cnt_f_nxt == F_FULL) begin
      r_floaded <= 1'b1;
    end
  end

  assign w_f_reuse = r_floaded;
`else
  assign w_f_reuse = 1'b0;
`endif

  assign w_full_x = (r_cnt_x == X_FULL);
  assign w_full_f = (r_cnt_f == F_FULL) | w_f_reuse;
  assign w_nk     = LG_DATA_N'(r_n) + LG_DATA_N'(r_k);

  // r_live keeps every output low for the cycle right after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
      r_cnt_x <= '0;
      r_cnt_f <= '0;
      r_k     <= '0;
      r_n     <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt_x <= w_cnt_x_nxt;
      r_cnt_f <= w_cnt_f_nxt;
      r_k     <= w_k_nxt;
      r_n     <= w_n_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_x_nxt = r_cnt_x;
    w_cnt_f_nxt = r_cnt_f;
    w_k_nxt     = r_k;
    w_n_nxt     = r_n;
    s_ready_x   = 1'b0;
    s_ready_f   = 1'b0;
    m_valid_y   = 1'b0;
    wr_en_x     = 1'b0;
    wr_en_f     = 1'b0;
    clear_acc   = 1'b0;
    en_acc      = 1'b0;
    run_done    = 1'b0;
    addr_x      = '0;
    addr_f      = '0;
    unique case (r_state)
      S_LOAD: begin
        if (r_live) begin
          s_ready_x   = ~w_full_x;
          s_ready_f   = ~w_full_f;
          wr_en_x     = s_valid_x & ~w_full_x;
          wr_en_f     = s_valid_f & ~w_full_f;
          addr_x      = r_cnt_x[LG_DATA_N-1:0];
          addr_f      = r_cnt_f[LG_FILTER_N-1:0];
          w_cnt_x_nxt = r_cnt_x + (LG_DATA_N+1)'(wr_en_x);
          w_cnt_f_nxt = r_cnt_f + (LG_FILTER_N+1)'(wr_en_f);
          if ((w_cnt_x_nxt == X_FULL) &&
              ((w_cnt_f_nxt == F_FULL) || w_f_reuse)) begin
            w_state_nxt = S_COMP;
            w_k_nxt     = '0;
            w_n_nxt     = '0;
          end
        end
      end
      S_COMP: begin
        en_acc    = 1'b1;
        clear_acc = (r_k == '0);
        addr_x    = w_nk;
        addr_f    = r_k;
        if (r_k == K_LAST) begin
          w_state_nxt = S_OUT;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      S_OUT: begin
        m_valid_y = 1'b1;
        addr_x    = w_nk;
        addr_f    = r_k;
        if (m_ready_y) begin
          if (r_n == N_LAST) begin
            run_done    = 1'b1;
            w_state_nxt = S_LOAD;
            w_cnt_x_nxt = '0;
            w_cnt_f_nxt = '0;
          end else begin
            w_state_nxt = S_COMP;
            w_n_nxt     = r_n + 1'b1;
            w_k_nxt     = '0;
          end
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

endmodule
